// File: rtl/icache_tl_line_responder.sv
// TileLink-UL manager for ICache line fills: queues A-channel Gets, reads one 64B line at a time, returns it as two 256-bit AccessAckData beats.
// Define ICACHE_TL_RESP_BEAT_GAP_EN to insert BEAT_GAP idle cycles after each D beat.
module icache_tl_line_responder #(
  parameter int REQ_DEPTH = 4,
  parameter int SOURCE_W  = 4,
  parameter int ADDR_W    = 48,
  parameter int BEAT_GAP  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                auto_client_out_a_valid,
  output logic                auto_client_out_a_ready,
  input  logic [SOURCE_W-1:0] auto_client_out_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_client_out_a_bits_address,
  output logic                auto_client_out_d_valid,
  output logic [2:0]          auto_client_out_d_bits_opcode,
  output logic [SOURCE_W-1:0] auto_client_out_d_bits_source,
  output logic [255:0]        auto_client_out_d_bits_data,
  output logic                auto_client_out_d_bits_corrupt,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-7:0]   mem_req_addr,
  input  logic                mem_resp_valid,
  input  logic [511:0]        mem_resp_data,
  input  logic                mem_resp_error,
  output logic                busy
);
  localparam int LineW = ADDR_W - 6;
  localparam int EntW  = SOURCE_W + LineW;
  localparam int PtrW  = $clog2(REQ_DEPTH);
  localparam int CntW  = PtrW + 1;

  typedef enum logic [2:0] {IDLE, MREQ, MWAIT, BEAT0, BEAT1, GAP} state_e;

  state_e              state_q, state_d;
  logic [EntW-1:0]     fifo_q [REQ_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                live_q;
  logic [511:0]        line_q;
  logic                err_q;
  logic [SOURCE_W-1:0] src_q;
  logic [2:0]          opcode_q;
  logic                hi_q;
  logic                push, pop;
  logic [SOURCE_W-1:0] head_src;
  logic [LineW-1:0]    head_line;
  logic                unused_ok;

  // live_q keeps a_ready low through the cycle following reset
  assign auto_client_out_a_ready = live_q && !reset && (count_q != CntW'(REQ_DEPTH));
  assign push = auto_client_out_a_valid && auto_client_out_a_ready;
  assign {head_src, head_line} = fifo_q[rd_ptr_q];

  assign mem_req_valid = (state_q == MREQ);
  assign mem_req_addr  = head_line;

  assign auto_client_out_d_valid        = (state_q == BEAT0) || (state_q == BEAT1);
  assign auto_client_out_d_bits_opcode  = opcode_q;
  assign auto_client_out_d_bits_source  = src_q;
  assign auto_client_out_d_bits_data    = hi_q ? line_q[511:256] : line_q[255:0];
  assign auto_client_out_d_bits_corrupt = err_q;
  assign busy = (count_q != '0) || (state_q != IDLE);

`ifdef ICACHE_TL_RESP_BEAT_GAP_EN
  logic [7:0] gap_q;
  logic       after_b1_q;
  logic       gap_done;
  assign gap_done  = (gap_q == 8'(BEAT_GAP - 1));
  assign unused_ok = ^auto_client_out_a_bits_address[5:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      gap_q      <= '0;
      after_b1_q <= 1'b0;
    end else begin
      gap_q <= (state_q == GAP) ? gap_q + 8'd1 : 8'd0;
      if (state_q == BEAT0) after_b1_q <= 1'b0;
      if (state_q == BEAT1) after_b1_q <= 1'b1;
    end
  end
`else
  assign unused_ok = ^{auto_client_out_a_bits_address[5:0], 8'(BEAT_GAP)};
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  if (count_q != '0) state_d = MREQ;
      MREQ:  if (mem_req_ready) state_d = MWAIT;
      MWAIT: if (mem_resp_valid) state_d = BEAT0;
`ifdef ICACHE_TL_RESP_BEAT_GAP_EN
      BEAT0: state_d = GAP;
      BEAT1: begin
        pop     = 1'b1;
        state_d = GAP;
      end
      GAP: begin
        if (gap_done) begin
          if (!after_b1_q)          state_d = BEAT1;
          else if (count_q != '0)   state_d = MREQ;
          else                      state_d = IDLE;
        end
      end
`else
      BEAT0: state_d = BEAT1;
      // The popped entry may be replaced by a same-cycle push
      BEAT1: begin
        pop     = 1'b1;
        state_d = (count_q > CntW'(1) || push) ? MREQ : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= 1'b0;
      line_q   <= '0;
      err_q    <= 1'b0;
      src_q    <= '0;
      opcode_q <= 3'd0;
      hi_q     <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (state_q == MWAIT && mem_resp_valid) begin
        line_q   <= mem_resp_data;
        err_q    <= mem_resp_error;
        src_q    <= head_src;
        opcode_q <= 3'd1;
        hi_q     <= 1'b0;
      end
      if (state_d == BEAT1) hi_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= {auto_client_out_a_bits_source,
                                   auto_client_out_a_bits_address[ADDR_W-1:6]};
  end
endmodule

// File: tb/tb_icache_tl_line_responder.sv
// Directed bench for icache_tl_line_responder: the memory side is driven inline, one line at a time.
module tb_icache_tl_line_responder;
  logic         clock = 1'b0;
  logic         reset;
  logic         a_valid;
  logic         a_ready;
  logic [3:0]   a_src;
  logic [47:0]  a_addr;
  logic         d_valid;
  logic [2:0]   d_opcode;
  logic [3:0]   d_source;
  logic [255:0] d_data;
  logic         d_corrupt;
  logic         mreq_v;
  logic         mreq_rdy;
  logic [41:0]  mreq_addr;
  logic         resp_v;
  logic [511:0] resp_d;
  logic         resp_e;
  logic         busy;

  int checks = 0;
  int errors = 0;

`ifdef ICACHE_TL_RESP_BEAT_GAP_EN
  localparam int TAIL = 3;
`else
  localparam int TAIL = 1;
`endif

  always #5 clock = ~clock;

  icache_tl_line_responder dut (
    .clock                          (clock),
    .reset                          (reset),
    .auto_client_out_a_valid        (a_valid),
    .auto_client_out_a_ready        (a_ready),
    .auto_client_out_a_bits_source  (a_src),
    .auto_client_out_a_bits_address (a_addr),
    .auto_client_out_d_valid        (d_valid),
    .auto_client_out_d_bits_opcode  (d_opcode),
    .auto_client_out_d_bits_source  (d_source),
    .auto_client_out_d_bits_data    (d_data),
    .auto_client_out_d_bits_corrupt (d_corrupt),
    .mem_req_valid                  (mreq_v),
    .mem_req_ready                  (mreq_rdy),
    .mem_req_addr                   (mreq_addr),
    .mem_resp_valid                 (resp_v),
    .mem_resp_data                  (resp_d),
    .mem_resp_error                 (resp_e),
    .busy                           (busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mkline(input logic [31:0] seed);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = 32'hC0DE_0000 ^ seed;
    lo = 32'h1357_0000 | seed;
    return {{8{hi}}, {8{lo}}};
  endfunction

  task automatic serve_line(input logic [41:0] exp_addr, input int lat,
                            input logic [511:0] data, input logic err);
    int n = 0;
    while (mreq_v !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("mreq_wait", n < 40, 1'b1);
    chk("mreq_addr", mreq_addr, exp_addr);
    mreq_rdy = 1'b1;
    step();
    mreq_rdy = 1'b0;
    repeat (lat - 1) step();
    resp_v = 1'b1;
    resp_d = data;
    resp_e = err;
    step();
    resp_v = 1'b0;
    resp_e = 1'b0;
  endtask

  task automatic expect_line(input logic [3:0] src, input logic [511:0] line, input logic err);
    int n = 0;
    while (d_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("d_wait", n < 40, 1'b1);
    chk("b0_valid", d_valid, 1'b1);
    chk("b0_opcode", d_opcode, 3'd1);
    chk("b0_source", d_source, src);
    chk("b0_data", d_data, line[255:0]);
    chk("b0_corrupt", d_corrupt, err);
    step();
`ifdef ICACHE_TL_RESP_BEAT_GAP_EN
    chk("gap_a", d_valid, 1'b0);
    step();
    chk("gap_b", d_valid, 1'b0);
    chk("gap_hold", d_data, line[255:0]);
    step();
`endif
    chk("b1_valid", d_valid, 1'b1);
    chk("b1_opcode", d_opcode, 3'd1);
    chk("b1_source", d_source, src);
    chk("b1_data", d_data, line[511:256]);
    chk("b1_corrupt", d_corrupt, err);
`ifdef ICACHE_TL_RESP_BEAT_GAP_EN
    step();
    chk("tail_a", d_valid, 1'b0);
    step();
    chk("tail_b", d_valid, 1'b0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] ln;
    reset = 1'b1; a_valid = 1'b0; a_src = '0; a_addr = '0;
    mreq_rdy = 1'b0; resp_v = 1'b0; resp_d = '0; resp_e = 1'b0;
    step();
    step();
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_opcode", d_opcode, 3'd0);
    chk("rst_source", d_source, 4'd0);
    chk("rst_data", d_data, 256'd0);
    chk("rst_corrupt", d_corrupt, 1'b0);
    chk("rst_mreq_v", mreq_v, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    chk("post_rst_a_ready", a_ready, 1'b0);
    step();
    chk("live_a_ready", a_ready, 1'b1);

    // Single Get, memory answers 3 cycles after accepting
    a_valid = 1'b1; a_src = 4'h3; a_addr = 48'h0000_8000_0040;
    step();
    a_valid = 1'b0;
    chk("no_bypass", mreq_v, 1'b0);
    chk("busy_queued", busy, 1'b1);
    ln = mkline(32'h1);
    serve_line(42'h200_0001, 3, ln, 1'b0);
    expect_line(4'h3, ln, 1'b0);
    repeat (TAIL) step();
    chk("idle_d_valid", d_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("hold_source", d_source, 4'h3);
    chk("hold_data", d_data, ln[511:256]);
    chk("hold_opcode", d_opcode, 3'd1);

    // Offset bits dropped from the line address
    a_valid = 1'b1; a_src = 4'h5; a_addr = 48'h1234_5678_9A7F;
    step();
    a_valid = 1'b0;
    ln = mkline(32'h2);
    serve_line(42'h048_D159_E269, 1, ln, 1'b0);
    expect_line(4'h5, ln, 1'b0);
    repeat (TAIL) step();

    // Fill the queue while memory stalls
    for (int i = 0; i < 4; i++) begin
      chk("t3_a_ready", a_ready, 1'b1);
      a_valid = 1'b1; a_src = i[3:0]; a_addr = 48'((i + 1) * 4096);
      step();
    end
    a_src = 4'h9; a_addr = 48'h0000_0000_F000;
    chk("t3_full", a_ready, 1'b0);
    step();
    a_valid = 1'b0;
    chk("t3_stall_v", mreq_v, 1'b1);
    chk("t3_stall_addr", mreq_addr, 42'd64);
    step();
    step();
    chk("t3_hold_v", mreq_v, 1'b1);
    chk("t3_hold_addr", mreq_addr, 42'd64);
    for (int i = 0; i < 4; i++) begin
      ln = mkline(32'(16 + i));
      serve_line(42'((i + 1) * 64), 2, ln, 1'b0);
      expect_line(i[3:0], ln, 1'b0);
      if (i == 0) begin
        chk("t3_ready_at_pop", a_ready, 1'b0);
        step();
        chk("t3_ready_after_pop", a_ready, 1'b1);
      end
    end
    repeat (TAIL + 2) step();
    chk("t3_no_extra_d", d_valid, 1'b0);
    chk("t3_no_extra_busy", busy, 1'b0);

    // Error on the middle line of three
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1; a_src = 4'(4 + k); a_addr = 48'(32'h2_0000 + k * 64);
      step();
    end
    a_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ln = mkline(32'(32 + k));
      serve_line(42'(32'h800 + k), 2, ln, k == 1);
      expect_line(4'(4 + k), ln, k == 1);
    end
    repeat (TAIL) step();

    // Reset while waiting on memory, then a stale response
    a_valid = 1'b1; a_src = 4'h7; a_addr = 48'h0000_0003_0000;
    step();
    a_valid = 1'b0;
    step();
    chk("t5_mreq", mreq_v, 1'b1);
    mreq_rdy = 1'b1;
    step();
    mreq_rdy = 1'b0;
    reset = 1'b1;
    step();
    chk("t5_rst_d_valid", d_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_mreq", mreq_v, 1'b0);
    chk("t5_rst_a_ready", a_ready, 1'b0);
    chk("t5_rst_source", d_source, 4'd0);
    reset = 1'b0;
    resp_v = 1'b1; resp_d = mkline(32'h77); resp_e = 1'b1;
    step();
    resp_v = 1'b0; resp_e = 1'b0;
    chk("t5_stale_d_valid", d_valid, 1'b0);
    chk("t5_stale_busy", busy, 1'b0);
    step();
    chk("t5_after_d_valid", d_valid, 1'b0);
    chk("t5_after_busy", busy, 1'b0);
    chk("t5_after_data", d_data, 256'd0);
    chk("t5_after_corrupt", d_corrupt, 1'b0);
    chk("t5_after_a_ready", a_ready, 1'b1);
    a_valid = 1'b1; a_src = 4'h8; a_addr = 48'h0000_0004_0000;
    step();
    a_valid = 1'b0;
    ln = mkline(32'h88);
    serve_line(42'h1000, 1, ln, 1'b0);
    expect_line(4'h8, ln, 1'b0);
    repeat (TAIL) step();
    chk("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
